// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: opcodes, fetch FSM encoding and default widths.
package mips_pkg;

  localparam int unsigned DEFAULT_PC_WIDTH    = 16;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_JMP = 6'b010100;
  localparam logic [5:0] OP_LD  = 6'b011110;
  localparam logic [5:0] OP_HLT = 6'b010001;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment, otherwise holds.
module pc_reg #(
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_addr,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_d, pc_q;

  // Increment wraps modulo 2^PC_WIDTH by natural truncation.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives synchronous instruction memory, squashes the
// wrong-path slot after a jump, re-presents a held word under stall_pm and latches on halt.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   stall_pm,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [5:0]             op,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   valid
);

  fetch_state_e state_q, state_d;

  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    addr_q;
  logic [INSTR_WIDTH-1:0] hold_q;
  logic                   hold_valid_q;
  logic                   squash_q;
  logic                   pc_inc;
  logic                   pc_load;
  logic                   halt_now;

  pc_reg #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (reset),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (jump_addr),
    .pc        (pc_q)
  );

  always_comb begin
    state_d  = state_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    imem_en  = 1'b1;
    instr    = '0;
    valid    = 1'b0;
    halt_now = 1'b0;
    unique case (state_q)
      StFill: begin
        pc_inc  = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (stall_pm) begin
          instr = hold_q;
          valid = hold_valid_q;
        end else if (!squash_q) begin
          instr = imem_data;
          valid = 1'b1;
        end
        halt_now = valid && (instr[INSTR_WIDTH-1 -: 6] == OP_HLT);
        // A jump loads the PC even while stalled; the squash slot covers the in-flight word.
        pc_load  = jump_en;
        pc_inc   = !jump_en && !stall;
        if (halt_now) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        imem_en = 1'b0;
        instr   = hold_q;
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      addr_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      squash_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_inc || pc_load) begin
        addr_q <= pc_q;
      end
      if (!stall_pm) begin
        hold_q       <= instr;
        hold_valid_q <= valid;
      end
      squash_q <= pc_load;
    end
  end

  assign imem_addr = pc_q;
  assign pc_out    = addr_q;
  assign op        = instr[INSTR_WIDTH-1 -: 6];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding `stall_control_block`.
- Owns the program counter (PC) and drives the synchronous instruction memory.
- Presents the fetched instruction and its 6-bit `op` field downstream.
- Honours `stall` (freeze PC) and `stall_pm` (re-present the held instruction).
- Handles jump redirects with a one-slot squash, and latches a halt state.

## Interface
Parameters:
- `PC_WIDTH`, 16: PC and memory address width.
- `INSTR_WIDTH`, 32: instruction width; opcode is bits `[INSTR_WIDTH-1 -: 6]`.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  one clock; reset is asynchronous and active-low.
- `stall`  input  1  from `stall_control_block`; freezes the PC.
- `stall_pm`  input  1  from `stall_control_block`; selects the held instruction.
- `jump_en`  input  1  redirect request from execute.
- `jump_addr`  input  PC_WIDTH  redirect target.
- `imem_addr`  output  PC_WIDTH  memory read address.
- `imem_en`  output  1  memory read enable.
- `imem_data`  input  INSTR_WIDTH  read data, valid one cycle after the address is presented.
- `instr`  output  INSTR_WIDTH  instruction to decode.
- `op`  output  6  opcode of `instr`; connects to `stall_control_block.op`.
- `pc_out`  output  PC_WIDTH  address of the instruction currently on `instr`.
- `valid`  output  1  `instr` is a real fetched instruction, not an inserted NOP.

## Operation
State machine: `FILL`, `RUN`, `HALT`.

- **`FILL`**
  - Entered on reset.
  - `instr`=0, `valid`=0, `imem_en`=1.
  - PC increments once; the FSM moves to `RUN` next cycle.
- **`RUN`**
  - PC update:
    - `jump_en`=1: `pc_q <= jump_addr`, regardless of `stall`.
    - else `stall`=0: `pc_q <= pc_q + 1`.
    - else: PC holds.
  - `imem_addr` = `pc_q`. `addr_q` registers `imem_addr` whenever the PC advances or loads, and drives `pc_out`.
  - Instruction mux, in priority order:
    - `stall_pm`=1: `instr` = `hold_q`.
    - `squash_q`=1: `instr`=0, `valid`=0.
    - else: `instr` = `imem_data`, `valid`=1.
  - `hold_q <= instr` every cycle that `stall_pm`=0.
  - `squash_q <= jump_en`. It kills the wrong-path word already in flight for exactly one cycle.
  - `op` = `instr[INSTR_WIDTH-1 -: 6]`, combinational from the mux.
- **`HALT`**
  - Entered at the clock edge where `valid`=1 and `op`=`OP_HLT` in `RUN`.
  - PC frozen, `imem_en`=0.
  - `instr` = `hold_q`, the halt word, so the stall block keeps stalling.
  - `jump_en` is ignored. Only reset exits.

Arithmetic and boundary rules:
- PC increment is modulo 2^PC_WIDTH: `0xFFFF` wraps to `0x0000` with no flag.
- `jump_en` and `stall` together: jump wins; the squash slot still applies.
- A `stall_pm` cycle never updates `hold_q`.
- Reset asserted mid-operation clears everything immediately. All state returns to `FILL` with PC=0.

## Timing
Reset values:
- `pc_q`=0, `imem_addr`=0, `addr_q`=0, `pc_out`=0.
- `hold_q`=0, `instr`=0, `op`=0, `valid`=0, `squash_q`=0.
- `imem_en`=1, state=`FILL`.

Latency and cycle rules:
- Address-to-`instr` latency is 1 cycle.
- The first valid instruction (address 0) appears on `instr` 2 edges after reset release.
- Jump taken at edge N: edge N+1 shows NOP with `valid`=0; edge N+2 shows `mem[jump_addr]`.
- `stall_pm` selection is combinational: same-cycle effect on `instr` and `op`.

## Structure
- Shared package `mips_pkg`:
  - opcode constants `OP_NOP`=6'b000000, `OP_JMP`=6'b010100, `OP_LD`=6'b011110, `OP_HLT`=6'b010001;
  - the fetch-state encoding;
  - the `PC_WIDTH`/`INSTR_WIDTH` defaults.
- One natural sub-module: `pc_reg`, holding the PC register with increment, load and hold logic.
- FSM, hold register and mux stay in `fetch_stage`.

## Test plan
- **Reset release, no stalls.** Memory holds `mem[i]`=i+0x100.
  - Edge 2 after release: `instr`=0x100, `pc_out`=0, `valid`=1.
  - Each following edge: value +1.
- **Stall hold.** `stall`=1 and `stall_pm`=1 for 2 cycles while `instr`=0x103.
  - `instr` stays 0x103 and `imem_addr` stays frozen.
  - First edge after release: 0x104.
- **Jump.** `jump_en`=1 with `jump_addr`=0x20 while `stall`=0.
  - Next cycle: `instr`=0, `valid`=0.
  - Cycle after: `instr`=`mem[0x20]`, `pc_out`=0x20.
- **Jump during stall.** Asserting `jump_en` with `stall`=1 still loads the PC: `pc_q`=0x20 after the edge.
- **Halt.** `mem[5]` has `op`=6'b010001.
  - After it is fetched: state `HALT`, `imem_en`=0, `op` held at 6'b010001 for 20 cycles.
  - `reset` pulse low: PC=0, state `FILL`.
- **Wrap and async reset.** Jump to 0xFFFF: next fetch address is 0x0000. `reset` asserted mid-cycle clears `instr` and `valid` before the next edge.
